// File: rtl/np_frame_scheduler.sv
// Shares an 8-pixel NeoPixel controller between two requesters via a shadow frame.
// Define NP_SCHED_AUTOREFRESH_EN to resend the frame every REFRESH_PERIOD cycles.
//
// state        | meaning
// IDLE         | waiting for dirty frame or flush with controller ready
// LOAD         | streaming shadow[0..7] into the controller, one pixel per cycle
// GO           | one-cycle send strobe
// WAIT_BUSY    | waiting for controller to drop ready
// WAIT_READY   | waiting for controller to finish the send
// GAP          | enforced idle time between frames
module np_frame_scheduler #(
    parameter int MIN_GAP        = 50000,
    parameter int REFRESH_PERIOD = 2500000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic [2:0]  a_pixel,
    input  logic [23:0] a_rgb,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [2:0]  b_pixel,
    input  logic [23:0] b_rgb,
    output logic        b_ack,
    input  logic        flush,
    output logic [7:0]  np_red,
    output logic [7:0]  np_green,
    output logic [7:0]  np_blue,
    output logic [2:0]  np_pixel,
    output logic        np_load,
    output logic        np_go,
    input  logic        np_ready,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int GAP_LOAD = (MIN_GAP < 1) ? 0 : MIN_GAP - 1;
    localparam int GAP_W    = (GAP_LOAD < 1) ? 1 : $clog2(GAP_LOAD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GO,
        S_WAIT_BUSY,
        S_WAIT_READY,
        S_GAP
    } state_t;

    state_t             state, state_nxt;
    logic [23:0]        shadow [8];
    logic               dirty;
    logic               flush_pending;
    logic               rr_b;
    logic [2:0]         idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [15:0]        frame_cnt;
    logic               start_frame;
    logic               frame_done;
    logic               grant_ok;
    logic               grant_a;
    logic               grant_b;
    logic [2:0]         wr_pixel;
    logic [23:0]        wr_rgb;
    logic               refresh_hit;

    // Acks are held low while in reset so every output is quiet during reset.
    assign grant_ok = reset_n && (state != S_LOAD);
    assign grant_a  = grant_ok && a_req && (!b_req || !rr_b);
    assign grant_b  = grant_ok && b_req && (!a_req || rr_b);
    assign a_ack    = grant_a;
    assign b_ack    = grant_b;
    assign wr_pixel = grant_a ? a_pixel : b_pixel;
    assign wr_rgb   = grant_a ? a_rgb : b_rgb;

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        frame_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (np_ready && (dirty || flush_pending)) begin
                    state_nxt   = S_LOAD;
                    start_frame = 1'b1;
                end
            end
            S_LOAD: begin
                if (idx == 3'd7) state_nxt = S_GO;
            end
            S_GO:         state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!np_ready) state_nxt = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (np_ready) begin
                    state_nxt  = S_GAP;
                    frame_done = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_nxt = S_IDLE;
            end
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        np_load     = (state == S_LOAD);
        np_go       = (state == S_GO);
        busy        = (state != S_IDLE);
        np_pixel    = 3'd0;
        np_red      = 8'd0;
        np_green    = 8'd0;
        np_blue     = 8'd0;
        frame_count = frame_cnt;
        if (state == S_LOAD) begin
            np_pixel                   = idx;
            {np_red, np_green, np_blue} = shadow[idx];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            gap_cnt   <= '0;
            frame_cnt <= 16'd0;
            rr_b      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_frame)
                idx <= 3'd0;
            else if (state == S_LOAD)
                idx <= idx + 3'd1;
            if (frame_done)
                gap_cnt <= GAP_W'(GAP_LOAD);
            else if ((state == S_GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - GAP_W'(1);
            if (frame_done)
                frame_cnt <= frame_cnt + 16'd1;
            if (grant_a)
                rr_b <= 1'b1;
            else if (grant_b)
                rr_b <= 1'b0;
        end
    end

    // A write or flush landing in the IDLE->LOAD cycle wins over the clear,
    // so it is carried into the next frame rather than lost.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) shadow[i] <= 24'd0;
            dirty         <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            if (grant_a || grant_b)
                shadow[wr_pixel] <= wr_rgb;
            if (grant_a || grant_b)
                dirty <= 1'b1;
            else if (start_frame)
                dirty <= 1'b0;
            if (flush || refresh_hit)
                flush_pending <= 1'b1;
            else if (start_frame)
                flush_pending <= 1'b0;
        end
    end

`ifdef NP_SCHED_AUTOREFRESH_EN
    localparam int REF_LOAD = (REFRESH_PERIOD < 1) ? 0 : REFRESH_PERIOD - 1;
    localparam int REF_W    = (REF_LOAD < 1) ? 1 : $clog2(REF_LOAD + 1);

    logic [REF_W-1:0] ref_cnt;

    assign refresh_hit = (ref_cnt == '0);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            ref_cnt <= REF_W'(REF_LOAD);
        else if (start_frame || refresh_hit)
            ref_cnt <= REF_W'(REF_LOAD);
        else
            ref_cnt <= ref_cnt - REF_W'(1);
    end
`else
    localparam int unused_refresh_period = REFRESH_PERIOD;

    assign refresh_hit = 1'b0;
`endif

endmodule

// File: tb/tb_np_frame_scheduler.sv
// Scoreboard bench for np_frame_scheduler with a simple controller model.
module tb_np_frame_scheduler;

    localparam int MIN_GAP = 10;
    localparam int SEND    = 5;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        a_req, b_req, flush;
    logic [2:0]  a_pixel, b_pixel;
    logic [23:0] a_rgb, b_rgb;
    logic        a_ack, b_ack;
    logic [7:0]  np_red, np_green, np_blue;
    logic [2:0]  np_pixel;
    logic        np_load, np_go, np_ready, busy;
    logic [15:0] frame_count;

    np_frame_scheduler #(.MIN_GAP(MIN_GAP), .REFRESH_PERIOD(400)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .a_req(a_req), .a_pixel(a_pixel), .a_rgb(a_rgb), .a_ack(a_ack),
        .b_req(b_req), .b_pixel(b_pixel), .b_rgb(b_rgb), .b_ack(b_ack),
        .flush(flush),
        .np_red(np_red), .np_green(np_green), .np_blue(np_blue),
        .np_pixel(np_pixel), .np_load(np_load), .np_go(np_go),
        .np_ready(np_ready), .busy(busy), .frame_count(frame_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Controller model: ready drops for SEND cycles after each go strobe.
    logic ready_en = 1'b0;
    int   send_cnt = 0;
    assign np_ready = ready_en && (send_cnt == 0);
    always @(posedge CLOCK_50) begin
        if (np_go) send_cnt <= SEND;
        else if (send_cnt != 0) send_cnt <= send_cnt - 1;
    end

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  pix;
        logic [23:0] rgb;
    } ld_t;

    ld_t         sb_q[$];
    int          go_cycs[$];
    logic [23:0] exp_shadow [8];
    int          total = 0;
    int          bad = 0;
    int          go_count = 0;
    logic        sb_on = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        ld_t e;
        if (reset_n && np_load && sb_on) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_load: pixel %0d loaded with no frame expected", np_pixel);
            end else begin
                e = sb_q.pop_front();
                check("load_pixel", 64'(np_pixel), 64'(e.pix));
                check("load_rgb", 64'({np_red, np_green, np_blue}), 64'(e.rgb));
            end
        end
        if (np_go) begin
            go_count++;
            go_cycs.push_back(cyc);
        end
    end

    task automatic push_frame();
        for (int i = 0; i < 8; i++) sb_q.push_back({3'(i), exp_shadow[i]});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        flush = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 8; i++) exp_shadow[i] = 24'd0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic write_a(input logic [2:0] pix, input logic [23:0] rgb);
        int n;
        a_pixel = pix;
        a_rgb   = rgb;
        a_req   = 1'b1;
        #1;
        n = 0;
        while (!a_ack && n < 50) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        check("write_a_ack", 64'(a_ack), 64'(1));
        @(posedge CLOCK_50);
        #1;
        a_req = 1'b0;
        exp_shadow[pix] = rgb;
    endtask

    task automatic wait_fc(input string name, input logic [15:0] target, input int budget);
        int n = 0;
        while (frame_count !== target && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, 64'(frame_count), 64'(target));
    endtask

    task automatic wait_go(input string name, input int target, input int budget);
        int n = 0;
        while (go_count < target && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, 64'(go_count), 64'(target));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge CLOCK_50);
        while (busy && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, 64'(busy), 64'(0));
    endtask

    initial begin
        int          gb;
        int          loads_seen;
        logic [15:0] fb;
        logic [1:0]  exp_ack [3];

        a_pixel = 3'd0; a_rgb = 24'd0; b_pixel = 3'd0; b_rgb = 24'd0;

        // Reset: every output quiet, even with both requests up.
        reset_n = 1'b0;
        a_req = 1'b1;
        b_req = 1'b1;
        flush = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        #1;
        check("reset_outputs",
              64'({a_ack, b_ack, np_red, np_green, np_blue, np_pixel, np_load, np_go, busy, frame_count}),
              64'(0));

        // Single write, full frame, latency from ack to load and go.
        ready_en = 1'b1;
        do_reset();
        write_a(3'd3, 24'h112233);
        push_frame();
        @(negedge CLOCK_50);
        check("load_not_yet", 64'(np_load), 64'(0));
        @(negedge CLOCK_50);
        check("first_load_n2", 64'({np_load, np_pixel}), 64'({1'b1, 3'd0}));
        repeat (8) @(negedge CLOCK_50);
        check("go_at_n10", 64'(np_go), 64'(1));
        wait_fc("frame_count_1", 16'd1, 100);
        wait_idle("idle_after_frame", 100);

        // Controller not ready: round-robin A,B,A, no loads until ready.
        ready_en = 1'b0;
        do_reset();
        exp_ack[0] = 2'b10;
        exp_ack[1] = 2'b01;
        exp_ack[2] = 2'b10;
        a_pixel = 3'd1; a_rgb = 24'hA1A2A3;
        b_pixel = 3'd2; b_rgb = 24'hB1B2B3;
        a_req = 1'b1;
        b_req = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rr_grant", 64'({a_ack, b_ack}), 64'(exp_ack[i]));
            @(negedge CLOCK_50);
            #1;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        exp_shadow[1] = 24'hA1A2A3;
        exp_shadow[2] = 24'hB1B2B3;
        loads_seen = 0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (np_load) loads_seen++;
        end
        check("no_load_not_ready", 64'(loads_seen), 64'(0));
        push_frame();
        gb = go_count;
        ready_en = 1'b1;
        wait_go("go_after_ready", gb + 1, 100);
        wait_fc("frame_count_rr", 16'd1, 100);
        wait_idle("idle_after_rr", 100);

        // Request during LOAD waits, is acked in GO, shows in the next frame.
        do_reset();
        gb = go_count;
        write_a(3'd0, 24'h0000FF);
        push_frame();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        b_pixel = 3'd0;
        b_rgb   = 24'hFF0000;
        b_req   = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("ack_blocked_in_load", 64'({np_load, b_ack}), 64'({1'b1, 1'b0}));
            @(negedge CLOCK_50);
            #1;
        end
        check("ack_in_go", 64'({np_go, b_ack}), 64'({1'b1, 1'b1}));
        @(posedge CLOCK_50);
        #1;
        b_req = 1'b0;
        exp_shadow[0] = 24'hFF0000;
        push_frame();
        wait_go("second_frame_go", gb + 2, 200);
        wait_fc("frame_count_2", 16'd2, 100);
        wait_idle("idle_after_two", 100);

        // Writes every cycle: go spacing = 1 + SEND + MIN_GAP + 1 + 8 + 1 = 26.
        do_reset();
        sb_on = 1'b0;
        go_cycs.delete();
        gb = go_count;
        a_pixel = 3'd5;
        a_rgb   = 24'h123456;
        a_req   = 1'b1;
        wait_go("stream_gos", gb + 4, 600);
        if (go_cycs.size() >= 4)
            for (int i = 0; i < 3; i++)
                check("go_spacing", 64'(go_cycs[i + 1] - go_cycs[i]), 64'(26));
        a_req = 1'b0;
        exp_shadow[5] = 24'h123456;
        repeat (80) @(negedge CLOCK_50);
        sb_on = 1'b1;
        gb = go_count;
        fb = frame_count;
        repeat (40) @(negedge CLOCK_50);
`ifndef NP_SCHED_AUTOREFRESH_EN
        check("clean_no_frame", 64'(go_count), 64'(gb));
`endif
        push_frame();
        flush = 1'b1;
        @(negedge CLOCK_50);
        flush = 1'b0;
        repeat (80) @(negedge CLOCK_50);
`ifndef NP_SCHED_AUTOREFRESH_EN
        check("flush_one_frame", 64'(go_count), 64'(gb + 1));
        check("flush_frame_count", 64'(frame_count), 64'(fb + 16'd1));
`endif

        // Reset in the middle of LOAD: outputs drop at once, nothing sent.
        write_a(3'd7, 24'hABCDEF);
        push_frame();
        repeat (4) @(negedge CLOCK_50);
        check("mid_load_before_reset", 64'(np_load), 64'(1));
        gb = go_count;
        reset_n = 1'b0;
        #1;
        check("mid_load_reset_outputs",
              64'({a_ack, b_ack, np_red, np_green, np_blue, np_pixel, np_load, np_go, busy, frame_count}),
              64'(0));
        sb_q.delete();
        for (int i = 0; i < 8; i++) exp_shadow[i] = 24'd0;
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        check("no_go_after_reset", 64'(go_count), 64'(gb));
        check("frame_count_reset", 64'(frame_count), 64'(0));

`ifdef NP_SCHED_AUTOREFRESH_EN
        sb_on = 1'b0;
        gb = go_count;
        wait_go("autorefresh_frames", gb + 2, 1200);
        sb_on = 1'b1;
        repeat (40) @(negedge CLOCK_50);
        sb_q.delete();
`endif

        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
